// File: rtl/hazard_fwd_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for a 5-stage RISC-V pipeline.
// Keeps a shadow of the ID/EX, EX/MEM and MEM/WB destination tags. Define HAZARD_PERF_CNT_EN to add saturating perf counters.
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  idex_bubble,
    output logic                  ifid_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt,
    output logic [CNT_W-1:0]      perf_fwd_cnt
`endif
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    // ID/EX shadow entry
    logic                  r_idex_v;
    logic [REG_ADDR_W-1:0] r_idex_rd;
    logic [REG_ADDR_W-1:0] r_idex_rs1;
    logic [REG_ADDR_W-1:0] r_idex_rs2;
    logic                  r_idex_rw;
    logic                  r_idex_mr;

    // EX/MEM shadow entry; the load flag only matters while the load sits in ID/EX,
    // so it is not carried past that stage.
    logic                  r_exmem_v;
    logic [REG_ADDR_W-1:0] r_exmem_rd;
    logic                  r_exmem_rw;

    // MEM/WB shadow entry
    logic                  r_memwb_v;
    logic [REG_ADDR_W-1:0] r_memwb_rd;
    logic                  r_memwb_rw;

    logic                  w_load_use;
    logic                  w_flush;
    logic                  w_stall;
    logic                  w_bubble;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;

    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  exmem_v,
        input logic                  exmem_rw,
        input logic [REG_ADDR_W-1:0] exmem_rd,
        input logic                  memwb_v,
        input logic                  memwb_rw,
        input logic [REG_ADDR_W-1:0] memwb_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (exmem_v && exmem_rw && (exmem_rd != '0) && (exmem_rd == rs))
            sel = SEL_EXMEM;
        else if (memwb_v && memwb_rw && (memwb_rd != '0) && (memwb_rd == rs))
            sel = SEL_MEMWB;
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_select(r_idex_rs1, r_exmem_v, r_exmem_rw, r_exmem_rd,
                             r_memwb_v, r_memwb_rw, r_memwb_rd);
        w_fwd_b = fwd_select(r_idex_rs2, r_exmem_v, r_exmem_rw, r_exmem_rd,
                             r_memwb_v, r_memwb_rw, r_memwb_rd);
    end

    assign w_load_use = id_valid && r_idex_v && r_idex_mr && (r_idex_rd != '0) &&
                        ((r_idex_rd == id_rs1) || (r_idex_rd == id_rs2));

    // A taken branch squashes the dependent instruction anyway, so flush wins over stall.
    // The branch input is masked during reset so no control leaks out while cleared.
    assign w_flush  = ex_branch_taken && arst_n;
    assign w_stall  = w_load_use && !w_flush;
    assign w_bubble = w_stall || w_flush;

    assign fwd_a_sel   = w_fwd_a;
    assign fwd_b_sel   = w_fwd_b;
    assign stall       = w_stall;
    assign idex_bubble = w_bubble;
    assign ifid_flush  = w_flush;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idex_v   <= 1'b0;
            r_idex_rd  <= '0;
            r_idex_rs1 <= '0;
            r_idex_rs2 <= '0;
            r_idex_rw  <= 1'b0;
            r_idex_mr  <= 1'b0;
        end else if (w_bubble) begin
            // bubble carries all-zero tags so it can never look like a consumer or producer
            r_idex_v   <= 1'b0;
            r_idex_rd  <= '0;
            r_idex_rs1 <= '0;
            r_idex_rs2 <= '0;
            r_idex_rw  <= 1'b0;
            r_idex_mr  <= 1'b0;
        end else begin
            r_idex_v   <= id_valid;
            r_idex_rd  <= id_rd;
            r_idex_rs1 <= id_rs1;
            r_idex_rs2 <= id_rs2;
            r_idex_rw  <= id_reg_write;
            r_idex_mr  <= id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_exmem_v  <= 1'b0;
            r_exmem_rd <= '0;
            r_exmem_rw <= 1'b0;
            r_memwb_v  <= 1'b0;
            r_memwb_rd <= '0;
            r_memwb_rw <= 1'b0;
        end else begin
            r_exmem_v  <= r_idex_v;
            r_exmem_rd <= r_idex_rd;
            r_exmem_rw <= r_idex_rw;
            r_memwb_v  <= r_exmem_v;
            r_memwb_rd <= r_exmem_rd;
            r_memwb_rw <= r_exmem_rw;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic             w_fwd_any;

    assign w_fwd_any = (w_fwd_a != SEL_RF) || (w_fwd_b != SEL_RF);

    // counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (w_fwd_any && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
    assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule
